// File: rtl/formula_simplifier.sv
// DPLL clause simplifier: drops satisfied clauses and strips falsified literals, one clause per cycle.
// Define EARLY_CONFLICT_EN to abort the scan on the first clause that becomes empty.
package common;
   localparam int MAX_CLAUSES = 10;
   localparam int MAX_LITS    = 5;
   localparam int VAR_W       = 3;

   typedef struct packed {
      logic [VAR_W-1:0] vid;
      logic             pol;
   } lit_t;

   typedef struct packed {
      lit_t [MAX_LITS-1:0] lits;
      logic [2:0]          cnt;
   } clause_t;

   typedef struct packed {
      clause_t [MAX_CLAUSES-1:0] cls;
      logic [3:0]                cnt;
   } formula;

   localparam lit_t    zero_lit     = '0;
   localparam clause_t zero_clause  = '0;
   localparam formula  zero_formula = '0;
endpackage

module formula_simplifier
   import common::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   start,
   input  formula din,
   input  lit_t   assign_lit,
   input  logic   stack_full,
   output logic   busy,
   output logic   done,
   output formula dout,
   output logic   push_en,
   output logic   sat,
   output logic   conflict,
   output logic   overflow
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t     state, state_nx;
   formula     work, wnext, wfin;
   lit_t       a;
   clause_t    cur, red;
   logic [3:0] idx, n, out_cnt, cnext, nclamp;
   logic [2:0] k;
   logic       hit, empty, last;
   logic       conflict_q, sat_q;

   assign nclamp = (din.cnt > 4'(MAX_CLAUSES)) ? 4'(MAX_CLAUSES) : din.cnt;
   assign last   = (idx == n - 4'd1);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = (nclamp == 4'd0) ? DONE : SCAN;
`ifdef EARLY_CONFLICT_EN
         SCAN: if (empty || last) state_nx = DONE;
`else
         SCAN: if (last) state_nx = DONE;
`endif
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Reduce the current clause; zero slots are dropped during compaction.
   always_comb begin
      cur = work.cls[idx];
      red = zero_clause;
      hit = 1'b0;
      k   = 3'd0;
      for (int j = 0; j < MAX_LITS; j++) begin
         if (cur.lits[j].vid != '0 && cur.lits[j].vid == a.vid) begin
            if (cur.lits[j].pol == a.pol) hit = 1'b1;
         end else if (cur.lits[j].vid != '0) begin
            red.lits[k] = cur.lits[j];
            k = k + 3'd1;
         end
      end
      red.cnt = k;
      empty   = ~hit & (k == 3'd0);
      wnext   = work;
      cnext   = out_cnt;
      if (~hit && k != 3'd0) begin
         wnext.cls[out_cnt] = red;
         cnext = out_cnt + 4'd1;
      end
      wfin = wnext;
      for (int c = 0; c < MAX_CLAUSES; c++)
         if (4'(c) >= cnext) wfin.cls[c] = zero_clause;
      wfin.cnt = cnext;
   end

   // Survivors are compacted in place: slot out_cnt never runs ahead of idx.
   always_ff @(posedge clock) begin
      if (reset) begin
         work       <= zero_formula;
         a          <= zero_lit;
         idx        <= '0;
         n          <= '0;
         out_cnt    <= '0;
         conflict_q <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               a          <= assign_lit;
               idx        <= '0;
               n          <= nclamp;
               out_cnt    <= '0;
               conflict_q <= 1'b0;
               sat_q      <= (nclamp == 4'd0);
               work       <= (nclamp == 4'd0) ? zero_formula : din;
            end
            SCAN: begin
               idx        <= idx + 4'd1;
               out_cnt    <= cnext;
               conflict_q <= conflict_q | empty;
`ifdef EARLY_CONFLICT_EN
               if (empty) begin
                  work  <= zero_formula;
                  sat_q <= 1'b0;
               end else if (last) begin
                  work  <= wfin;
                  sat_q <= (cnext == 4'd0) & ~conflict_q;
               end else begin
                  work <= wnext;
               end
`else
               if (last) begin
                  work  <= wfin;
                  sat_q <= (cnext == 4'd0) & ~(conflict_q | empty);
               end else begin
                  work <= wnext;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy     = (state == SCAN);
      done     = (state == DONE);
      push_en  = (state == DONE) & ~conflict_q & ~stack_full;
      overflow = (state == DONE) & ~conflict_q & stack_full;
      sat      = sat_q;
      conflict = conflict_q;
      dout     = work;
   end

endmodule
